// File: rtl/ltpi_data_channel_responder_if.sv
// ltpi_data_channel_responder_if: request/response frames plus Avalon-MM host bus of the LTPI data-channel responder
//   master: responder side (consumes requests, produces responses, masters Avalon)
//   slave : environment side (frame receiver/transmitter and Avalon slave)
interface ltpi_data_channel_responder_if #(parameter int TAG_W = 4);
  logic             req_valid;
  logic             req_ready;
  logic [TAG_W-1:0] req_tag;
  logic [7:0]       req_cmd;
  logic [31:0]      req_addr;
  logic [3:0]       req_be;
  logic [31:0]      req_data;
  logic             resp_valid;
  logic             resp_ready;
  logic [TAG_W-1:0] resp_tag;
  logic [7:0]       resp_cmd;
  logic [1:0]       resp_status;
  logic [31:0]      resp_data;
  logic [31:0]      avm_address;
  logic             avm_read;
  logic             avm_write;
  logic [31:0]      avm_writedata;
  logic [3:0]       avm_byteenable;
  logic [31:0]      avm_readdata;
  logic             avm_readdatavalid;
  logic             avm_waitrequest;
  modport master (
    input  req_valid, req_tag, req_cmd, req_addr, req_be, req_data, resp_ready,
           avm_readdata, avm_readdatavalid, avm_waitrequest,
    output req_ready, resp_valid, resp_tag, resp_cmd, resp_status, resp_data,
           avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
  );
  modport slave (
    output req_valid, req_tag, req_cmd, req_addr, req_be, req_data, resp_ready,
           avm_readdata, avm_readdatavalid, avm_waitrequest,
    input  req_ready, resp_valid, resp_tag, resp_cmd, resp_status, resp_data,
           avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
  );
endinterface

// File: rtl/ltpi_data_channel_responder.sv
// ltpi_data_channel_responder: executes LTPI read/write request frames on Avalon-MM and returns one response each
//   clk_i   : clock
//   reset_i : asynchronous active-high reset
//   bus     : request/response frames and Avalon host port (master modport)
//   busy_o  : FSM not idle
module ltpi_data_channel_responder #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TAG_W          = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  ltpi_data_channel_responder_if.master bus,
  output logic                          busy_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;
  localparam logic [7:0] CMD_RD = 8'h00;
  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [1:0] ST_OK = 2'd0;
  localparam logic [1:0] ST_TO = 2'd1;
  localparam logic [1:0] ST_UNSUP = 2'd2;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       status_q, status_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             to_w;
  logic             sup_w;
  assign to_w  = cnt_q == CNT_MAX;
  assign sup_w = bus.req_cmd == CMD_RD || bus.req_cmd == CMD_WR;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    status_d = status_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        tag_d    = bus.req_tag;
        cmd_d    = bus.req_cmd;
        addr_d   = bus.req_addr;
        be_d     = bus.req_be;
        wdata_d  = bus.req_data;
        cnt_d    = '0;
        rdata_d  = '0;
        status_d = sup_w ? ST_OK : ST_UNSUP;
        state_d  = sup_w ? ISSUE : RESP;
      end
      ISSUE: begin
        cnt_d = to_w ? cnt_q : cnt_q + 1'b1;
        // A read accepted by the slave still has to see its data before the deadline.
        if (!bus.avm_waitrequest && (cmd_q == CMD_WR || bus.avm_readdatavalid)) begin
          rdata_d = cmd_q == CMD_WR ? 32'h0 : bus.avm_readdata;
          state_d = RESP;
        end else if (to_w) begin
          status_d = ST_TO;
          state_d  = RESP;
        end else if (!bus.avm_waitrequest) state_d = WAIT_RD;
      end
      WAIT_RD: begin
        cnt_d = to_w ? cnt_q : cnt_q + 1'b1;
        if (bus.avm_readdatavalid) begin
          rdata_d = bus.avm_readdata;
          state_d = RESP;
        end else if (to_w) begin
          status_d = ST_TO;
          state_d  = RESP;
        end
      end
      default: if (bus.resp_ready) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tag_q    <= '0;
      cmd_q    <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      status_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tag_q    <= tag_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
    end
  // Strobes decode straight from the state register so an asynchronous reset drops them at once.
  assign bus.avm_read       = state_q == ISSUE && cmd_q == CMD_RD;
  assign bus.avm_write      = state_q == ISSUE && cmd_q == CMD_WR;
  assign bus.avm_address    = addr_q;
  assign bus.avm_byteenable = be_q;
  assign bus.avm_writedata  = wdata_q;
  assign bus.req_ready      = state_q == IDLE && !reset_i;
  assign bus.resp_valid     = state_q == RESP;
  assign bus.resp_tag       = tag_q;
  assign bus.resp_cmd       = cmd_q;
  assign bus.resp_status    = status_q;
  assign bus.resp_data      = rdata_q;
  assign busy_o             = state_q != IDLE;
endmodule
